// File: rtl/risc_v_fetch_unit.sv
// Instruction-fetch stage: issues one outstanding imem request at the current PC,
// buffers returned instructions with their PCs, and hands them to decode.
module risc_v_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_en,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    state_t                state, state_nxt;
    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] req_pc, aligned_pc;
    logic                  req_fire, push, pop, has_space;

    assign aligned_pc    = {pc[ADDR_WIDTH-1:2], 2'b00};
    assign imem_req_addr = aligned_pc;
    // A request is only issued from IDLE, where no slot is outstanding, so the
    // plain count test already reserves room for the response.
    assign has_space     = count < CNT_W'(FIFO_DEPTH);
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign pc_en         = !reset && (req_fire || flush);

    assign out_valid     = (count != '0) && !flush;
    assign pop           = out_valid && out_ready;
    assign out_pc        = fifo_mem[rd_ptr].pc;
    assign out_instr     = fifo_mem[rd_ptr].instr;

    // Request/response FSM: next state, request valid and FIFO push.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        case (state)
            IDLE: begin
                imem_req_valid = !reset && !flush && has_space;
                if (imem_req_valid && imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push      = !flush;
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and PC capture for the in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) req_pc <= aligned_pc;
        end
    end

    // Buffer storage; contents are don't-care until count says otherwise.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{pc: req_pc, instr: imem_rsp_data};
    end

    // Buffer pointers and occupancy; flush empties the buffer at the edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule
